// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the fifo write-port arbiter
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

   // Index width that stays legal for a single-entry vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating priority pick: first set bit after base, wrapping to base last
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] base_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   int            c;
   logic [IW-1:0] ci;

   // Scan from the far end so the candidate closest to base+1 overwrites the rest.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      c       = 0;
      ci      = '0;
      for (int k = N; k >= 1; k--) begin
         c  = (int'(base_i) + k) % N;
         ci = IW'(c);
         if (req_i[ci]) begin
            found_o = 1'b1;
            idx_o   = ci;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter with bounded bursts sharing one fifo write port
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] din,
   output logic [N_REQ-1:0]       gnt,
   output logic                   fifo_wr_en,
   output logic [WIDTH-1:0]       fifo_din,
   input  logic                   fifo_full
);

   localparam int IW = idx_w(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          owner_req;
   logic          owned_hold;
   logic [IW-1:0] base;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] sel;
   logic          acc;
   logic [CW-1:0] cnt_new;
   logic          burst_done;

   assign owner_req  = req[owner_q];
   assign owned_hold = (state_q == ST_OWNED) && owner_req;
   // A withdrawing owner rotates from itself so its neighbour wins in the same cycle.
   assign base       = (state_q == ST_OWNED && !owner_req) ? owner_q : last_q;

   rr_priority_pick #(.N(N_REQ)) u_pick (
      .req_i   (req),
      .base_i  (base),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign sel        = owned_hold ? owner_q : pick_idx;
   assign acc        = pick_found && !fifo_full;
   assign fifo_wr_en = acc;
   assign fifo_din   = din[int'(sel)*WIDTH +: WIDTH];

   always_comb begin
      gnt = '0;
      if (acc) gnt[sel] = 1'b1;
   end

   assign cnt_new    = owned_hold ? cnt_q + CW'(1) : CW'(1);
   assign burst_done = (int'(cnt_new) == MAX_BURST);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (acc) begin
         if (burst_done) begin
            state_d = ST_IDLE;
            last_d  = sel;
            cnt_d   = '0;
         end else begin
            state_d = ST_OWNED;
            owner_d = sel;
            cnt_d   = cnt_new;
         end
      end else if (state_q == ST_OWNED && !owner_req) begin
         state_d = ST_IDLE;
         last_d  = owner_q;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= IW'(N_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
